acl_tilt_bargraph: RTL and testbench
====================================

// Module: acl_tilt_bargraph
// PURPOSE
//  Generalised tilt display engine for PmodACL axis data. Takes NUM_CH packed signed
//  accelerometer samples per transfer from the SPI front end and filters each channel.
//  Maps each channel to a plus/minus thermometer bar of NUM_LED active-low LEDs, plus an
//  "any tilt" LED. Sits between SPIcomponent outputs and board LED pins.
// PARAMETERS
//  NUM_CH     2   number of axis channels in in_data
//  DATA_W     10  sample width, two's complement
//  NUM_LED    4   LEDs per direction per channel
//  DEAD_ZONE  16  |avg| <= DEAD_ZONE gives an empty bar
//  STEP_LOG2  5   counts per LED step = 2**STEP_LOG2
//  AVG_LOG2   2   EMA shift; used only with ACL_AVG_EN
// PORTS
//  CLK          in   1               system clock
//  RST          in   1               synchronous reset, active-high
//  in_valid     in   1               sample set available
//  in_ready     out  1               high only in IDLE
//  in_data      in   NUM_CH*DATA_W   channel c = in_data[c*DATA_W +: DATA_W]
//  clr_overrun  in   1               clears sticky overrun
//  led_plus_n   out  NUM_CH*NUM_LED  channel c = [c*NUM_LED +: NUM_LED], 0 = lit
//  led_minus_n  out  NUM_CH*NUM_LED  same layout, negative direction
//  led_any_n    out  1               AND of all plus/minus bits (0 = some LED lit)
//  out_valid    out  1               1-cycle pulse when LED outputs update
//  overrun      out  1               sticky: in_valid seen while in_ready = 0
// BEHAVIOUR
//  Reset:
//   - FSM=IDLE; led_plus_n, led_minus_n, led_any_n all 1s.
//   - out_valid=0, overrun=0; filter state and primed flags cleared.
//   - Reset mid-operation aborts the sequence; no partial LED update is issued.
//  Handshake:
//   - A transfer is accepted at the edge where in_valid & in_ready; in_data is captured there.
//   - in_valid while busy is dropped and sets overrun. Set wins over a same-cycle clr_overrun.
//  FSM: IDLE -> FILT(ch) -> MAP(ch) -> ... per channel, 0..NUM_CH-1 -> UPD -> IDLE.
//   - FILT and MAP take one cycle each per channel; UPD takes one cycle.
//   - With acceptance at edge T, the new outputs and the out_valid pulse are registered at
//     edge T+2*NUM_CH+1; in_ready returns 1 in the same cycle.
//   - LED outputs hold their values between UPD cycles.
//  Map, per channel:
//   - mag = |avg|, with -2**(DATA_W-1) saturating to 2**(DATA_W-1)-1.
//   - level = 0 if mag <= DEAD_ZONE, else min(NUM_LED, ((mag-DEAD_ZONE) >> STEP_LOG2) + 1).
//   - avg >= 0: plus bits [k] = 0 for k < level; all minus bits = 1.
//   - avg < 0: mirror image; all plus bits = 1.
//  led_any_n is registered at UPD from the new bar values.
// CONFIGURATION
//  ACL_AVG_EN defined:
//   - Per-channel EMA with accumulator acc of DATA_W+AVG_LOG2 bits, signed.
//   - First sample after reset: acc = s << AVG_LOG2, and the channel is marked primed.
//   - Later samples: acc = acc - (acc >>> AVG_LOG2) + sext(s).
//   - avg = acc >>> AVG_LOG2.
//  ACL_AVG_EN undefined: avg = captured sample; FILT is still one cycle, so latency is identical.
// TESTING
//  - No ACL_AVG_EN, ch0 = +100, ch1 = 0 -> after 5 cycles: out_valid=1;
//    plus_n[3:0]=4'b1000, minus_n[3:0]=4'b1111; ch1 bars all 1s; led_any_n=0.
//  - No ACL_AVG_EN, ch0 = -512 -> mag saturates to 511; minus_n[3:0]=4'b0000,
//    plus_n[3:0]=4'b1111.
//  - ch0 = +16 and ch1 = -16 (dead-zone edge) -> all bars 1s, led_any_n=1;
//    ch0 = +17 -> plus_n[3:0]=4'b1110.
//  - ACL_AVG_EN, ch0 samples 200, 0, 0 -> avg 200, 150, 112;
//    plus_n[3:0] = 4'b0000, 4'b0000, 4'b0000.
//  - in_valid held high continuously -> 1 transfer every 6 cycles; overrun=1 after the
//    first busy cycle; clr_overrun alone clears it; clr_overrun in a busy in_valid cycle keeps it 1.
//  - Assert RST at FILT(ch1) -> no out_valid; LEDs all 1s; next transfer after reset
//    re-primes the filter.

Source files
------------

// File: rtl/acl_tilt_bargraph_if.sv
// acl_tilt_bargraph_if: sample-set handshake from the SPI front end.
// Master drives in_valid/in_data; the display engine returns in_ready.
interface acl_tilt_bargraph_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/acl_tilt_bargraph.sv
// acl_tilt_bargraph: filtered PmodACL axis samples to +/- thermometer LED bars.
// Define ACL_AVG_EN to enable the per-channel EMA filter.
module acl_tilt_bargraph #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 10,
  parameter int NUM_LED   = 4,
  parameter int DEAD_ZONE = 16,
  parameter int STEP_LOG2 = 5,
  parameter int AVG_LOG2  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  acl_tilt_bargraph_if.slave        bus,
  input  logic                      clr_overrun,
  output logic [NUM_CH*NUM_LED-1:0] led_plus_n,
  output logic [NUM_CH*NUM_LED-1:0] led_minus_n,
  output logic                      led_any_n,
  output logic                      out_valid,
  output logic                      overrun
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LW = $clog2(NUM_LED + 1);
  localparam int AW = DATA_W + AVG_LOG2;
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] DZ = DATA_W'(DEAD_ZONE);
  localparam logic [DATA_W-1:0] NL = DATA_W'(NUM_LED);

  typedef enum logic [1:0] {IDLE, FILT, MAP, UPD} state_t;

  state_t state, state_n;
  logic [CW-1:0] ch, ch_n;
  logic accept;
  logic [DATA_W-1:0] cap [NUM_CH];
  logic [DATA_W-1:0] avg, filt_avg;
  logic signed [AW-1:0] sx;
  logic [NUM_CH*NUM_LED-1:0] nxt_plus, nxt_minus;
  logic [DATA_W-1:0] mag, steps;
  logic [LW-1:0] level;
  logic [NUM_LED-1:0] bar;

  assign bus.in_ready = (state == IDLE);
  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    unique case (state)
      IDLE: if (accept) begin
        state_n = FILT;
        ch_n    = '0;
      end
      FILT: state_n = MAP;
      MAP: if (ch == LAST) begin
        state_n = UPD;
      end else begin
        state_n = FILT;
        ch_n    = ch + 1'b1;
      end
      UPD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sx = AW'($signed(cap[ch]));

`ifdef ACL_AVG_EN
  logic signed [AW-1:0] acc [NUM_CH];
  logic signed [AW-1:0] acc_n;
  logic [NUM_CH-1:0] primed;

  // First sample seeds the accumulator so the average starts at the sample.
  always_comb begin
    if (primed[ch]) acc_n = acc[ch] - (acc[ch] >>> AVG_LOG2) + sx;
    else            acc_n = sx <<< AVG_LOG2;
    filt_avg = DATA_W'(acc_n >>> AVG_LOG2);
  end
`else
  assign filt_avg = DATA_W'(sx);
`endif

  // Most negative code has no positive twin; clamp its magnitude.
  always_comb begin
    mag = avg[DATA_W-1] ? (~avg + 1'b1) : avg;
    if (avg[DATA_W-1] && (avg[DATA_W-2:0] == '0))
      mag = {1'b0, {(DATA_W-1){1'b1}}};
    steps = (mag - DZ) >> STEP_LOG2;
    if (mag <= DZ)        level = '0;
    else if (steps >= NL) level = LW'(NUM_LED);
    else                  level = LW'(steps) + 1'b1;
    for (int k = 0; k < NUM_LED; k++)
      bar[k] = (LW'(k) >= level);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      led_plus_n  <= '1;
      led_minus_n <= '1;
      led_any_n   <= 1'b1;
      nxt_plus    <= '1;
      nxt_minus   <= '1;
      avg         <= '0;
      for (int c = 0; c < NUM_CH; c++) cap[c] <= '0;
`ifdef ACL_AVG_EN
      primed <= '0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (bus.in_valid && !bus.in_ready) overrun <= 1'b1;
      else if (clr_overrun)              overrun <= 1'b0;
      if (accept)
        for (int c = 0; c < NUM_CH; c++)
          cap[c] <= bus.in_data[c*DATA_W +: DATA_W];
      if (state == FILT) begin
        avg <= filt_avg;
`ifdef ACL_AVG_EN
        acc[ch]    <= acc_n;
        primed[ch] <= 1'b1;
`endif
      end
      if (state == MAP) begin
        nxt_plus[ch*NUM_LED +: NUM_LED]  <= avg[DATA_W-1] ? '1 : bar;
        nxt_minus[ch*NUM_LED +: NUM_LED] <= avg[DATA_W-1] ? bar : '1;
      end
      if (state == UPD) begin
        led_plus_n  <= nxt_plus;
        led_minus_n <= nxt_minus;
        led_any_n   <= &{nxt_plus, nxt_minus};
        out_valid   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_acl_tilt_bargraph.sv
// tb_acl_tilt_bargraph: directed + random checks against an arithmetic model.
// Build with ACL_AVG_EN defined to exercise the EMA filter path.
module tb_acl_tilt_bargraph;
  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 10;
  localparam int NUM_LED = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr_overrun;
  logic [NUM_CH*NUM_LED-1:0] led_plus_n, led_minus_n;
  logic led_any_n, out_valid, overrun;

  int checks = 0;
  int failures = 0;
  int acc_m [NUM_CH];
  bit primed_m [NUM_CH];
  logic [7:0] exp_p, exp_m;

  acl_tilt_bargraph_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  acl_tilt_bargraph dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus),
    .clr_overrun(clr_overrun),
    .led_plus_n(led_plus_n),
    .led_minus_n(led_minus_n),
    .led_any_n(led_any_n),
    .out_valid(out_valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] bar_of(input int avg);
    int mag, lvl;
    logic [3:0] b;
    mag = (avg < 0) ? -avg : avg;
    if (mag > 511) mag = 511;
    if (mag <= 16) lvl = 0;
    else lvl = (mag - 16) / 32 + 1;
    if (lvl > 4) lvl = 4;
    b = 4'b1111;
    for (int k = 0; k < lvl; k++) b[k] = 1'b0;
    return b;
  endfunction

  task automatic model(input int s0, input int s1);
    int s [NUM_CH];
    int avg;
    s[0] = s0;
    s[1] = s1;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef ACL_AVG_EN
      if (primed_m[c]) acc_m[c] = acc_m[c] - (acc_m[c] >>> 2) + s[c];
      else begin
        acc_m[c] = s[c] * 4;
        primed_m[c] = 1'b1;
      end
      avg = acc_m[c] >>> 2;
`else
      avg = s[c];
`endif
      exp_p[c*4 +: 4] = (avg >= 0) ? bar_of(avg) : 4'hF;
      exp_m[c*4 +: 4] = (avg < 0) ? bar_of(avg) : 4'hF;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      acc_m[c] = 0;
      primed_m[c] = 1'b0;
    end
    exp_p = '1;
    exp_m = '1;
  endtask

  task automatic check_leds(input string tag);
    chk({tag, "_plus"}, 32'(led_plus_n), 32'(exp_p));
    chk({tag, "_minus"}, 32'(led_minus_n), 32'(exp_m));
    chk({tag, "_any"}, 32'(led_any_n), 32'(&{exp_p, exp_m}));
  endtask

  task automatic xfer(input int s0, input int s1, input string tag,
                      input bit busy_clr);
    int n;
    logic early;
    logic [9:0] a, b;
    a = s0[9:0];
    b = s1[9:0];
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data = {b, a};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model(s0, s1);
    early = 1'b0;
    if (busy_clr) begin
      bus.in_valid = 1'b1;
      clr_overrun = 1'b1;
    end
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 && busy_clr) begin
        bus.in_valid = 1'b0;
        clr_overrun = 1'b0;
        chk({tag, "_ovr_keep"}, 32'(overrun), 32'd1);
      end
      if (i < 5) early = early | out_valid;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    check_leds(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int s0, s1, d;
    int acc_at [$];
    logic seen;
    rst = 1'b1;
    clr_overrun = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    do_reset();

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    check_leds("rst");

    xfer(100, 0, "pos100", 1'b0);
    xfer(-512, 0, "neg512", 1'b0);
    xfer(16, -16, "dz_edge", 1'b0);
    xfer(17, 0, "dz_plus1", 1'b0);
    xfer(-300, 511, "mixed", 1'b0);
    chk("no_overrun", 32'(overrun), 32'd0);

    for (int i = 0; i < 20; i++) begin
      s0 = int'($urandom_range(1023)) - 512;
      s1 = int'($urandom_range(1023)) - 512;
      xfer(s0, s1, $sformatf("rnd%0d", i), 1'b0);
    end

    d = int'($urandom_range(1023)) - 512;
    @(negedge clk);
    for (int n = 0; n < 13; n++) begin
      if (n > 0) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = {d[9:0], d[9:0]};
      if (bus.in_ready) acc_at.push_back(n);
      if (n == 2) chk("ovr_set", 32'(overrun), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("hold_count", 32'(acc_at.size()), 32'd3);
    if (acc_at.size() == 3) begin
      chk("hold_gap1", 32'(acc_at[1] - acc_at[0]), 32'd6);
      chk("hold_gap2", 32'(acc_at[2] - acc_at[1]), 32'd6);
    end
    repeat (3) model(d, d);
    seen = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) seen = out_valid;
    end
    chk("hold_valid", 32'(seen), 32'd1);
    check_leds("hold");

    @(negedge clk);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    xfer(300, -200, "busy_clr", 1'b1);
    chk("ovr_after_busy", 32'(overrun), 32'd1);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = {10'd0, 10'd400};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    check_leds("abort");

    xfer(-150, 60, "reprime", 1'b0);
    xfer(40, -90, "after_reprime", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
